packet_dispatcher: RTL and testbench
====================================

Name: packet_dispatcher

Overview:
- Downstream consumer of the packet queue. When the queue is non-empty it pops one packet, decodes its numeric destination, and delivers it on a shared data bus to exactly one of NUM_DEST destination channels using a per-channel valid/ready handshake.
- Packets whose destination is out of range are dropped.
- Also checks that packet IDs arrive in sequence.
- Keeps a delivered count and a drop count for status reporting.

Parameters:
- ID_W, 32, packet ID width
- SRC_W, 8, numeric source-device field width
- DEST_W, 8, numeric destination field width
- PAYLOAD_W, 128, payload width
- NUM_DEST, 10, number of destination channels; valid dest values are 0..NUM_DEST-1

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  dispatch enable; when low, no new pop is started
- q_empty  in  1  queue empty flag
- q_pop  out  1  pop request to queue, one-cycle pulse
- q_id  in  ID_W  queue output ID, valid the cycle after q_pop
- q_src  in  SRC_W  queue output source
- q_dest  in  DEST_W  queue output destination
- q_payload  in  PAYLOAD_W  queue output payload
- tx_valid  out  NUM_DEST  one-hot valid, bit = destination channel
- tx_ready  in  NUM_DEST  per-channel ready
- tx_id  out  ID_W  captured ID
- tx_src  out  SRC_W  captured source
- tx_payload  out  PAYLOAD_W  captured payload
- busy  out  1  high in any state other than IDLE
- seq_err  out  1  sticky: an ID arrived out of sequence
- pkt_count  out  32  packets delivered, wraps at 2^32
- drop_count  out  16  packets dropped, saturates at 16'hFFFF

Behaviour:
- Reset (rst high at a clock edge):
  - state goes to IDLE; q_pop=0; tx_valid=0; tx_id/tx_src/tx_payload=0.
  - seq_err=0, pkt_count=0, drop_count=0, expected_id=0.
  - Reset has priority over every other event.
  - Reset mid-operation abandons the in-flight packet; it is not counted.
- States and transitions:
  - IDLE: if en && !q_empty, go to POP; otherwise stay.
  - POP: q_pop=1 for exactly this cycle; go to CAPT.
  - CAPT: sample q_id, q_src, q_payload and q_dest into registers. Then:
    - if q_dest < NUM_DEST, go to SEND;
    - else increment drop_count (saturating) and go to IDLE.
  - SEND: tx_valid[dest]=1, all other bits 0. tx_* buses hold the captured values and stay stable until the handshake.
    - Handshake completes on a cycle where tx_valid[dest] && tx_ready[dest]. On that edge, pkt_count increments and the state goes to IDLE.
    - Ready bits of other channels are ignored.
    - tx_valid never deasserts before the handshake, even if en drops.
- q_pop is a registered output: it equals 1 only in the POP state. It is never asserted while q_empty=1 was sampled in IDLE.
- Sequence check, done in CAPT for both dropped and delivered packets:
  - if q_id != expected_id, set seq_err (sticky until reset).
  - expected_id <= q_id + 1, modulo 2^ID_W.
- en deasserted in POP, CAPT or SEND: the current packet completes normally. Only the IDLE->POP transition is gated.
- Throughput:
  - minimum 3 cycles per delivered packet (POP, CAPT, SEND with ready=1), plus 1 IDLE cycle, so back-to-back packets take 4 cycles.
  - a dropped packet costs 3 cycles, including IDLE.
- tx_ready held low indefinitely: the block stalls in SEND and issues no further pops (backpressure to the queue).
- q_empty rising while in POP/CAPT is ignored; the pop already issued is honoured.
- busy = (state != IDLE).

Test Plan:
- Reset, then push 20 packets with IDs 0..19 and dest = (i+1)%10 into the queue; all tx_ready=1 -> 20 deliveries in order; each tx_valid is one-hot at bit (i+1)%10 with matching tx_id; pkt_count=20, seq_err=0, drop_count=0; q_pop never asserted after the queue is empty.
- Packet ID 5 with dest=12 between valid IDs 4 and 6 -> no tx_valid for ID 5; drop_count=1; pkt_count counts only the valid packets; seq_err stays 0.
- IDs 0,1,3 -> seq_err goes to 1 at CAPT of ID 3 and stays 1 while ID 4 and later follow; all three packets are still delivered.
- Packet to dest 2 with tx_ready[2]=0 for 50 cycles and tx_ready[7]=1 -> tx_valid=10'b0000000100 held; tx_payload stable; no q_pop; completes one cycle after tx_ready[2] rises; pkt_count +1.
- Queue holding 5 packets, en=0 -> no q_pop and busy=0; assert en in the middle of a SEND stall -> the packet completes and the next pop follows 1 cycle after IDLE.
- rst pulsed while in SEND -> next cycle tx_valid=0, state IDLE, all counters 0, seq_err=0; the next popped packet with ID 0 raises no seq_err.

Source files
------------

// File: rtl/packet_dispatcher.sv
// Pops packets from an upstream queue, drops those with an out-of-range
// destination, and delivers the rest on a one-hot valid/ready channel set.
module packet_dispatcher #(
  parameter int ID_W      = 32,
  parameter int SRC_W     = 8,
  parameter int DEST_W    = 8,
  parameter int PAYLOAD_W = 128,
  parameter int NUM_DEST  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 q_empty,
  output logic                 q_pop,
  input  logic [ID_W-1:0]      q_id,
  input  logic [SRC_W-1:0]     q_src,
  input  logic [DEST_W-1:0]    q_dest,
  input  logic [PAYLOAD_W-1:0] q_payload,
  output logic [NUM_DEST-1:0]  tx_valid,
  input  logic [NUM_DEST-1:0]  tx_ready,
  output logic [ID_W-1:0]      tx_id,
  output logic [SRC_W-1:0]     tx_src,
  output logic [PAYLOAD_W-1:0] tx_payload,
  output logic                 busy,
  output logic                 seq_err,
  output logic [31:0]          pkt_count,
  output logic [15:0]          drop_count
);

  typedef enum logic [1:0] {IDLE, POP, CAPT, SEND} state_t;

  state_t              state, state_next;
  logic [NUM_DEST-1:0] dest_dec;
  logic                dest_ok;
  logic                handshake;
  logic [ID_W-1:0]     expected_id;

  // A destination outside 0..NUM_DEST-1 decodes to all zeros and is dropped.
  always_comb begin
    dest_dec = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (q_dest == DEST_W'(i)) dest_dec[i] = 1'b1;
    end
  end

  assign dest_ok   = |dest_dec;
  assign handshake = |(tx_valid & tx_ready);
  assign q_pop     = (state == POP);
  assign busy      = (state != IDLE);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (en && !q_empty) state_next = POP;
      POP:  state_next = CAPT;
      CAPT: state_next = dest_ok ? SEND : IDLE;
      SEND: if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid    <= '0;
      tx_id       <= '0;
      tx_src      <= '0;
      tx_payload  <= '0;
      seq_err     <= 1'b0;
      pkt_count   <= '0;
      drop_count  <= '0;
      expected_id <= '0;
    end else begin
      if (state == CAPT) begin
        tx_id       <= q_id;
        tx_src      <= q_src;
        tx_payload  <= q_payload;
        tx_valid    <= dest_dec;
        expected_id <= q_id + 1'b1;
        if (q_id != expected_id) seq_err <= 1'b1;
        if (!dest_ok && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      end
      // tx_valid is non-zero only in SEND, so a handshake cannot fire elsewhere.
      if (handshake) begin
        tx_valid  <= '0;
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packet_dispatcher.sv
// Directed bench for packet_dispatcher: a queue model feeds the DUT and a
// transaction-level reference model is compared against the outputs every cycle.
module tb_packet_dispatcher;

  localparam int ID_W = 32, SRC_W = 8, DEST_W = 8, PAYLOAD_W = 128, NUM_DEST = 10;

  logic                 clk = 1'b0;
  logic                 rst, en, q_empty, q_pop, busy, seq_err;
  logic [ID_W-1:0]      q_id, tx_id;
  logic [SRC_W-1:0]     q_src, tx_src;
  logic [DEST_W-1:0]    q_dest;
  logic [PAYLOAD_W-1:0] q_payload, tx_payload;
  logic [NUM_DEST-1:0]  tx_valid, tx_ready;
  logic [31:0]          pkt_count;
  logic [15:0]          drop_count;

  always #5 clk = ~clk;

  packet_dispatcher #(
    .ID_W(ID_W), .SRC_W(SRC_W), .DEST_W(DEST_W), .PAYLOAD_W(PAYLOAD_W), .NUM_DEST(NUM_DEST)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .q_empty(q_empty), .q_pop(q_pop),
    .q_id(q_id), .q_src(q_src), .q_dest(q_dest), .q_payload(q_payload),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_id(tx_id), .tx_src(tx_src),
    .tx_payload(tx_payload), .busy(busy), .seq_err(seq_err),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  typedef struct {
    logic [ID_W-1:0]      id;
    logic [SRC_W-1:0]     src;
    logic [DEST_W-1:0]    dest;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  pkt_t fifo[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   pop_cyc[$];

  // Reference model: where the current packet is in its life (0 waiting,
  // 1 popping, 2 arriving, 3 offered), plus the status the block must report.
  int              m_phase;
  pkt_t            m_cap;
  logic [31:0]     m_pkt_count;
  int              m_drop;
  bit              m_seq_err;
  logic [ID_W-1:0] m_exp_id;
  logic [ID_W-1:0] m_deliv[$];

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic pkt_t mk(int id, int dest);
    pkt_t p;
    p.id      = ID_W'(id);
    p.src     = SRC_W'(id + 16);
    p.dest    = DEST_W'(dest);
    p.payload = {32'(id), ~32'(id), 32'(id * 3), 32'hC0DE0000 | 32'(id)};
    return p;
  endfunction

  task automatic push(int id, int dest);
    fifo.push_back(mk(id, dest));
    q_empty = 1'b0;
  endtask

  // Apply the rules for the clock edge that just passed, using the inputs held over it.
  task automatic model_edge();
    if (rst) begin
      m_phase = 0; m_cap = '{default: '0}; m_pkt_count = 0;
      m_drop = 0; m_seq_err = 0; m_exp_id = 0;
    end else begin
      case (m_phase)
        0: if (en && !q_empty) m_phase = 1;
        1: m_phase = 2;
        2: begin
          m_cap = '{q_id, q_src, q_dest, q_payload};
          if (q_id != m_exp_id) m_seq_err = 1;
          m_exp_id = q_id + 1;
          if (int'(q_dest) < NUM_DEST) m_phase = 3;
          else begin
            if (m_drop < 65535) m_drop++;
            m_phase = 0;
          end
        end
        default: if (tx_ready[int'(m_cap.dest)]) begin
          m_pkt_count++;
          m_deliv.push_back(m_cap.id);
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic compare();
    logic [NUM_DEST-1:0] ev;
    ev = (m_phase == 3) ? (NUM_DEST'(1) << m_cap.dest) : '0;
    check("q_pop", q_pop, m_phase == 1);
    check("busy", busy, m_phase != 0);
    check("tx_valid", tx_valid, ev);
    if (m_phase == 3) begin
      check("tx_id", tx_id, m_cap.id);
      check("tx_src", tx_src, m_cap.src);
      check("tx_payload", tx_payload, m_cap.payload);
    end
    check("seq_err", seq_err, m_seq_err);
    check("pkt_count", pkt_count, m_pkt_count);
    check("drop_count", drop_count, 16'(m_drop));
  endtask

  // One clock: model the edge, compare, then let the queue react to q_pop.
  task automatic tick();
    pkt_t p;
    @(negedge clk);
    cyc++;
    model_edge();
    compare();
    if (q_pop === 1'b1) begin
      pop_cyc.push_back(cyc);
      check("pop_on_empty", fifo.size() == 0, 1'b0);
      if (fifo.size() != 0) begin
        p = fifo.pop_front();
        q_id = p.id; q_src = p.src; q_dest = p.dest; q_payload = p.payload;
      end
    end
    q_empty = (fifo.size() == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo.delete();
    q_empty = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pop_cyc.delete();
    m_deliv.delete();
  endtask

  task automatic run_until_idle(int max);
    int k = 0;
    while ((fifo.size() != 0 || m_phase != 0) && k < max) begin
      tick();
      k++;
    end
    if (k >= max) check("drain_timeout", 1'b1, 1'b0);
  endtask

  task automatic wait_send(int max);
    int k = 0;
    while ((|tx_valid) !== 1'b1 && k < max) begin
      tick();
      k++;
    end
    if (k >= max) check("send_timeout", 1'b1, 1'b0);
  endtask

  logic [PAYLOAD_W-1:0] held_payload;

  initial begin
    rst = 1'b1; en = 1'b0; q_empty = 1'b1; tx_ready = '0;
    q_id = '0; q_src = '0; q_dest = '0; q_payload = '0;

    do_reset();
    check("rst_tx_valid", tx_valid, 10'b0);
    check("rst_q_pop", q_pop, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_id", tx_id, 32'h0);
    check("rst_pkt_count", pkt_count, 32'd0);

    // 20 in-order deliveries, destination (i+1)%10, all channels ready.
    en = 1'b1; tx_ready = '1;
    for (int i = 0; i < 20; i++) push(i, (i + 1) % 10);
    run_until_idle(200);
    repeat (5) tick();
    check("t1_pkt_count", pkt_count, 32'd20);
    check("t1_seq_err", seq_err, 1'b0);
    check("t1_drop_count", drop_count, 16'd0);
    check("t1_n_pops", pop_cyc.size(), 20);
    check("t1_pop_spacing", pop_cyc[1] - pop_cyc[0], 4);
    check("t1_order_n", m_deliv.size(), 20);
    for (int i = 0; i < 20; i++) check("t1_order", m_deliv[i], 32'(i));

    // Out-of-range destinations: 12 for ID 5 and the boundary value 10 for ID 7.
    do_reset();
    for (int i = 0; i < 8; i++) push(i, (i == 5) ? 12 : (i == 7) ? 10 : (i + 1) % 10);
    run_until_idle(200);
    check("t2_pkt_count", pkt_count, 32'd6);
    check("t2_drop_count", drop_count, 16'd2);
    check("t2_seq_err", seq_err, 1'b0);
    check("t2_drop_spacing", pop_cyc[6] - pop_cyc[5], 3);

    // Skipped ID 2: seq_err sticks, every packet is still delivered.
    do_reset();
    push(0, 1); push(1, 2); push(3, 3); push(4, 4); push(5, 5);
    run_until_idle(200);
    check("t3_seq_err", seq_err, 1'b1);
    check("t3_pkt_count", pkt_count, 32'd5);

    // Backpressure on channel 2 while channel 7 is ready.
    do_reset();
    tx_ready = 10'b0010000000;
    push(0, 2);
    wait_send(20);
    held_payload = tx_payload;
    repeat (50) tick();
    check("t4_valid_held", tx_valid, 10'b0000000100);
    check("t4_payload_stable", tx_payload, held_payload);
    tx_ready = 10'b0010000100;
    tick();
    check("t4_done_busy", busy, 1'b0);
    check("t4_pkt_count", pkt_count, 32'd1);

    // en low holds off pops; raising en mid-stall lets the packet finish normally.
    do_reset();
    en = 1'b0; tx_ready = '0;
    for (int i = 0; i < 5; i++) push(i, 3);
    repeat (10) tick();
    check("t5_idle_busy", busy, 1'b0);
    check("t5_idle_pop", pop_cyc.size(), 0);
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_send(20);
    repeat (5) tick();
    en = 1'b1;
    repeat (3) tick();
    check("t5_stall_busy", busy, 1'b1);
    tx_ready = '1;
    tick();
    check("t5_back_idle", busy, 1'b0);
    tick();
    check("t5_next_pop", q_pop, 1'b1);
    run_until_idle(200);
    check("t5_pkt_count", pkt_count, 32'd5);

    // Reset during a SEND stall abandons the packet; a fresh ID 0 is in sequence.
    tx_ready = '0;
    push(5, 3);
    wait_send(20);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_tx_valid", tx_valid, 10'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_pkt_count", pkt_count, 32'd0);
    check("t6_drop_count", drop_count, 16'd0);
    check("t6_seq_err", seq_err, 1'b0);
    tx_ready = '1;
    push(0, 4);
    run_until_idle(50);
    repeat (3) tick();
    check("t6_after_seq_err", seq_err, 1'b0);
    check("t6_after_pkt_count", pkt_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
